branch_resolve: RTL and testbench

Execute-stage branch resolution unit for the RV32I pipeline, directly downstream of the branch comparator. Drives the comparator's unsigned-select input, consumes its equal and less-than flags, and decides taken/not-taken for B-type, JAL and JALR. Computes and checks the target, then issues a registered PC redirect plus a timed flush of wrong-path fetch/decode stages. Keeps saturating performance counters for branches and taken branches.

---
 rtl/branch_resolve.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution for the RV32I pipeline.
// Decides taken/not-taken for B-type, JAL and JALR from the comparator
// flags, computes and alignment-checks the target, issues a registered PC
// redirect plus a timed flush of the wrong-path front end, and keeps
// saturating branch / taken-branch performance counters.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   valid_in, stall    instruction present in EX / pipeline hold
//   is_branch/is_jal/is_jalr, funct3, pc, imm, rs1_val   decoded instruction
//   un                 to comparator: unsigned compare select (funct3[1])
//   beq, blt           from comparator: equal / less-than flags
//   redirect_valid/pc  one-cycle fetch redirect and its target
//   flush              kill younger instructions, FLUSH_CYCLES long
//   link_addr          pc+4 of the last accepted JAL/JALR
//   misaligned         pulse: taken target not 4-byte aligned
//   illegal_br         pulse: B-type with funct3 010/011
//   branch_count, taken_count   saturating performance counters
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    output logic             un,
    input  logic             beq,
    input  logic             blt,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [XLEN-1:0]  link_addr,
    output logic             misaligned,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    // Counter wide enough to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_r, state_next_s;
    logic [FC_W-1:0]   fcnt_r, fcnt_next_s;

    logic              redirect_valid_r, flush_r, misaligned_r, illegal_br_r;
    logic [XLEN-1:0]   redirect_pc_r, link_addr_r;
    logic [CNT_W-1:0]  branch_count_r, taken_count_r;

    logic              accept_s, op_br_s, op_jal_s, op_jalr_s;
    logic              br_taken_s, br_illegal_s, taken_s, do_redirect_s;
    logic [XLEN-1:0]   target_s;

    // Comparator select: signedness is funct3[1] regardless of validity.
    assign un = funct3[1];

    // Decode, branch condition, target computation and accept qualification.
    always_comb begin
        accept_s     = valid_in & ~stall & (state_r == IDLE);
        // Malformed flag combinations decode to no operation at all.
        op_br_s      = is_branch & ~is_jal & ~is_jalr;
        op_jal_s     = ~is_branch & is_jal & ~is_jalr;
        op_jalr_s    = ~is_branch & ~is_jal & is_jalr;
        br_taken_s   = 1'b0;
        br_illegal_s = 1'b0;
        case (funct3)
            3'b000:  br_taken_s = beq;
            3'b001:  br_taken_s = ~beq;
            3'b100:  br_taken_s = blt;
            3'b110:  br_taken_s = blt;
            3'b101:  br_taken_s = ~blt;
            3'b111:  br_taken_s = ~blt;
            default: br_illegal_s = 1'b1;
        endcase
        if (op_jalr_s) begin
            target_s = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else begin
            target_s = pc + imm;
        end
        if (op_br_s) begin
            taken_s = br_taken_s;
        end else begin
            taken_s = op_jal_s | op_jalr_s;
        end
        // Bit 0 is never set on a taken target here, so bit 1 alone decides alignment.
        do_redirect_s = accept_s & taken_s & ~target_s[1];
    end

    // Next-state logic: redirect starts a flush window of FLUSH_CYCLES cycles.
    always_comb begin
        state_next_s = state_r;
        fcnt_next_s  = fcnt_r;
        case (state_r)
            IDLE: begin
                if (do_redirect_s) begin
                    state_next_s = FLUSH;
                    fcnt_next_s  = FC_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_next_s = IDLE;
                end
            end
            FLUSH: begin
                if (fcnt_r == {FC_W{1'b0}}) begin
                    state_next_s = IDLE;
                end else begin
                    fcnt_next_s = fcnt_r - FC_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                fcnt_next_s  = {FC_W{1'b0}};
            end
        endcase
    end

    // State register; flush is registered from the next state so it rises with redirect_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            fcnt_r  <= {FC_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fcnt_r  <= fcnt_next_s;
            flush_r <= (state_next_s == FLUSH);
        end
    end

    // Registered redirect, link and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
            link_addr_r      <= {XLEN{1'b0}};
            misaligned_r     <= 1'b0;
            illegal_br_r     <= 1'b0;
        end else begin
            redirect_valid_r <= do_redirect_s;
            misaligned_r     <= accept_s & taken_s & target_s[1];
            illegal_br_r     <= accept_s & op_br_s & br_illegal_s;
            if (do_redirect_s) begin
                redirect_pc_r <= target_s;
            end
            if (accept_s & (op_jal_s | op_jalr_s)) begin
                link_addr_r <= pc + XLEN'(4);
            end
        end
    end

    // Saturating performance counters for accepted and taken B-type instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_r <= {CNT_W{1'b0}};
            taken_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (accept_s & op_br_s & (branch_count_r != {CNT_W{1'b1}})) begin
                branch_count_r <= branch_count_r + CNT_W'(1);
            end
            if (accept_s & op_br_s & br_taken_s & (taken_count_r != {CNT_W{1'b1}})) begin
                taken_count_r <= taken_count_r + CNT_W'(1);
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush          = flush_r;
    assign link_addr      = link_addr_r;
    assign misaligned     = misaligned_r;
    assign illegal_br     = illegal_br_r;
    assign branch_count   = branch_count_r;
    assign taken_count    = taken_count_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed scenarios with literal expectations,
// followed by randomized stimulus, all checked every cycle against a
// behavioural model of the resolution rules. Built with CNT_W=4 so counter
// saturation is reachable.
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int FC    = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, valid_in, stall, is_branch, is_jal, is_jalr;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  pc, imm, rs1_val;
    logic             un, beq, blt;
    logic             redirect_valid, flush, misaligned, illegal_br;
    logic [XLEN-1:0]  redirect_pc, link_addr;
    logic [CNT_W-1:0] branch_count, taken_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: expected outputs for the current cycle.
    int          m_left;   // cycles (incl. current) flush stays high
    bit          m_rv, m_mis, m_ill;
    logic [31:0] m_rpc, m_link;
    int          m_bc, m_tc;

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .pc(pc), .imm(imm), .rs1_val(rs1_val),
        .un(un), .beq(beq), .blt(blt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .link_addr(link_addr), .misaligned(misaligned),
        .illegal_br(illegal_br), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, evaluate the rules, then compare after the edge.
    task automatic cycle(input bit r, input bit v, input bit s, input bit b, input bit j,
                         input bit jr, input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] rs, input bit eq, input bit lt);
        bit          acc, tk;
        logic [31:0] tgt;
        rst = r; valid_in = v; stall = s; is_branch = b; is_jal = j; is_jalr = jr;
        funct3 = f3; pc = p; imm = im; rs1_val = rs; beq = eq; blt = lt;
        #1;
        chk("un", {31'd0, un}, {31'd0, f3[1]});
        if (r) begin
            m_left = 0; m_rv = 0; m_mis = 0; m_ill = 0;
            m_rpc = 32'd0; m_link = 32'd0; m_bc = 0; m_tc = 0;
        end else begin
            m_rv = 0; m_mis = 0; m_ill = 0; tk = 0; tgt = 32'd0;
            acc = v && !s && (m_left == 0);
            if (m_left > 0) m_left--;
            if (acc) begin
                if (b && !j && !jr) begin
                    tgt = p + im;
                    if (m_bc < CMAX) m_bc++;
                    if      (f3 == 3'd0)                 tk = eq;
                    else if (f3 == 3'd1)                 tk = !eq;
                    else if (f3 == 3'd4 || f3 == 3'd6)   tk = lt;
                    else if (f3 == 3'd5 || f3 == 3'd7)   tk = !lt;
                    else                                  m_ill = 1;
                    if (tk && m_tc < CMAX) m_tc++;
                end else if (!b && j && !jr) begin
                    tk = 1; tgt = p + im; m_link = p + 32'd4;
                end else if (!b && !j && jr) begin
                    tk = 1; tgt = (rs + im) & 32'hFFFF_FFFE; m_link = p + 32'd4;
                end
                if (tk) begin
                    if (tgt[1]) m_mis = 1;
                    else begin m_rv = 1; m_rpc = tgt; m_left = FC; end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush", {31'd0, flush}, {31'd0, (m_left > 0)});
        chk("link_addr", link_addr, m_link);
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        chk("illegal_br", {31'd0, illegal_br}, {31'd0, m_ill});
        chk("branch_count", {28'd0, branch_count}, m_bc);
        chk("taken_count", {28'd0, taken_count}, m_tc);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    endtask

    initial begin
        int  k;
        bit  rb, rj, rjr;
        do_reset();
        do_reset();
        chk("lit_reset_flush", {31'd0, flush}, 32'd0);
        chk("lit_reset_rpc", redirect_pc, 32'd0);
        chk("lit_reset_bc", {28'd0, branch_count}, 32'd0);

        // Taken BEQ: redirect to 0x120, flush for two cycles.
        cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd0, 1, 0);
        chk("lit_beq_rv", {31'd0, redirect_valid}, 32'd1);
        chk("lit_beq_rpc", redirect_pc, 32'h120);
        chk("lit_beq_flush", {31'd0, flush}, 32'd1);
        chk("lit_beq_tc", {28'd0, taken_count}, 32'd1);
        idle();
        chk("lit_beq_flush2", {31'd0, flush}, 32'd1);
        idle();
        chk("lit_beq_flush_end", {31'd0, flush}, 32'd0);

        // BLTU not taken.
        cycle(0, 1, 0, 1, 0, 0, 3'b110, 32'h140, 32'h40, 32'd0, 0, 0);
        chk("lit_bltu_bc", {28'd0, branch_count}, 32'd2);
        chk("lit_bltu_tc", {28'd0, taken_count}, 32'd1);

        // JALR misaligned, then aligned.
        cycle(0, 1, 0, 0, 0, 1, 3'b000, 32'h200, 32'h4, 32'h1003, 0, 0);
        chk("lit_jalr_mis", {31'd0, misaligned}, 32'd1);
        chk("lit_jalr_mis_rv", {31'd0, redirect_valid}, 32'd0);
        cycle(0, 1, 0, 0, 0, 1, 3'b000, 32'h200, 32'h4, 32'h1001, 0, 0);
        chk("lit_jalr_rpc", redirect_pc, 32'h1004);
        chk("lit_jalr_link", link_addr, 32'h204);
        idle(); idle();

        // Taken BNE, then instructions during flush are ignored.
        cycle(0, 1, 0, 1, 0, 0, 3'b001, 32'h300, 32'h8, 32'd0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h304, 32'h8, 32'd0, 1, 0);
        cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h308, 32'h8, 32'd0, 1, 0);
        chk("lit_flush_ignored_bc", {28'd0, branch_count}, 32'd3);
        // Stall held with valid: nothing accepted until it drops.
        cycle(0, 1, 1, 1, 0, 0, 3'b000, 32'h400, 32'h8, 32'd0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 3'b000, 32'h400, 32'h8, 32'd0, 0, 0);
        chk("lit_stall_bc", {28'd0, branch_count}, 32'd3);
        cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h400, 32'h8, 32'd0, 0, 0);
        chk("lit_unstall_bc", {28'd0, branch_count}, 32'd4);

        // Illegal funct3, then reset in the middle of a flush.
        cycle(0, 1, 0, 1, 0, 0, 3'b010, 32'h500, 32'h8, 32'd0, 1, 1);
        chk("lit_illegal", {31'd0, illegal_br}, 32'd1);
        chk("lit_illegal_rv", {31'd0, redirect_valid}, 32'd0);
        cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h500, 32'h8, 32'd0, 1, 0);
        do_reset();
        chk("lit_rst_flush", {31'd0, flush}, 32'd0);
        chk("lit_rst_tc", {28'd0, taken_count}, 32'd0);

        // Saturation of the 4-bit counters.
        for (int i = 0; i < CMAX + 2; i++) begin
            cycle(0, 1, 0, 1, 0, 0, 3'b000, 32'h600, 32'h10, 32'd0, 1, 0);
            idle(); idle();
        end
        chk("lit_sat_tc", {28'd0, taken_count}, 32'hF);
        chk("lit_sat_bc", {28'd0, branch_count}, 32'hF);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 15);
            rb = (k < 9); rj = (k >= 9 && k < 12); rjr = (k >= 12 && k < 15);
            if (k == 15) begin
                rb = 1'($urandom); rj = 1'($urandom); rjr = 1'($urandom);
            end
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), rb, rj, rjr, 3'($urandom),
                  $urandom, {$urandom_range(0, 255), 2'($urandom)} ,
                  $urandom, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
